// File: rtl/sram_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_responder: 16-bit SRAM target with byte lanes, 1-clock registered reads.
// Define SRAM_RESPONDER_STATS_EN for RD_COUNT/WR_COUNT/PROTO_ERR.  Rev 1.0
// ---------------------------------------------------------------------------
module sram_responder #(
  parameter int ADDR_BITS = 12
) (
  input  logic        CLOCK48K,
  input  logic        nRESET,
  input  logic [19:0] SRAMaddress,
  input  logic        SRAM_nCE,
  input  logic        SRAM_nOE,
  input  logic        SRAM_nWE,
  input  logic        SRAM_nUB,
  input  logic        SRAM_nLB,
  inout  wire  [15:0] SRAMdata,
  output logic [15:0] RD_COUNT,
  output logic [15:0] WR_COUNT,
  output logic        PROTO_ERR
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          data_q, data_d;
  logic [15:0]          mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] addr;
  logic [19:0]          unused_addr;
  logic [15:0]          lane_mask;
  logic                 wr_en;
  logic                 bus_oe;

  // Upper address bits are deliberately ignored so the array aliases.
  assign addr        = SRAMaddress[ADDR_BITS-1:0];
  assign unused_addr = SRAMaddress;
  assign lane_mask   = {{8{~SRAM_nUB}}, {8{~SRAM_nLB}}};

  always_comb begin
    state_d = IDLE;
    data_d  = data_q;
    wr_en   = 1'b0;
    if (!SRAM_nCE) begin
      if (!SRAM_nWE) begin
        state_d = WRITE;
        wr_en   = 1'b1;
      end else if (!SRAM_nOE) begin
        state_d = READ;
        data_d  = mem[addr] & lane_mask;
      end
    end
  end

  always_ff @(posedge CLOCK48K or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= IDLE;
      data_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Array is never reset; a clock edge seen during reset must not commit.
  always_ff @(posedge CLOCK48K) begin
    if (nRESET && wr_en) begin
      if (!SRAM_nUB) mem[addr][15:8] <= SRAMdata[15:8];
      if (!SRAM_nLB) mem[addr][7:0]  <= SRAMdata[7:0];
    end
  end

  // Drive gate uses live controls so the bus releases without waiting a clock.
  assign bus_oe   = (state_q == READ) && !SRAM_nCE && !SRAM_nOE && SRAM_nWE;
  assign SRAMdata = bus_oe ? data_q : {16{1'bz}};

`ifdef SRAM_RESPONDER_STATS_EN
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;
  logic        proto_err_q, proto_err_d;

  always_comb begin
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    proto_err_d = proto_err_q;
    if (state_d == READ && state_q != READ && rd_count_q != 16'hFFFF)
      rd_count_d = rd_count_q + 16'd1;
    if (state_d == WRITE && state_q != WRITE && wr_count_q != 16'hFFFF)
      wr_count_d = wr_count_q + 16'd1;
    if (!SRAM_nCE && !SRAM_nOE && !SRAM_nWE)
      proto_err_d = 1'b1;
  end

  always_ff @(posedge CLOCK48K or negedge nRESET) begin
    if (!nRESET) begin
      rd_count_q  <= 16'h0000;
      wr_count_q  <= 16'h0000;
      proto_err_q <= 1'b0;
    end else begin
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign RD_COUNT  = rd_count_q;
  assign WR_COUNT  = wr_count_q;
  assign PROTO_ERR = proto_err_q;
`else
  assign RD_COUNT  = 16'h0000;
  assign WR_COUNT  = 16'h0000;
  assign PROTO_ERR = 1'b0;
`endif

endmodule
`default_nettype wire
